// File: rtl/datapath_seq_pkg.sv
// Shared opcode/funct constants, FSM state encoding and decoder
// for the RV64 datapath sequencer.
package datapath_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MEM  = 2'd2,
    WB   = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_LD   = 3'd1,
    OP_SD   = 3'd2,
    OP_ADDI = 3'd3,
    OP_ADD  = 3'd4,
    OP_SUB  = 3'd5
  } op_t;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [2:0] F3_D      = 3'b011;
  localparam logic [2:0] F3_ADD    = 3'b000;
  localparam logic [6:0] F7_ADD    = 7'b0000000;
  localparam logic [6:0] F7_SUB    = 7'b0100000;

  function automatic op_t decode(
    input logic [6:0] opc,
    input logic [2:0] f3,
    input logic [6:0] f7
  );
    op_t op;
    op = OP_NONE;
    if (opc == OPC_LOAD && f3 == F3_D)
      op = OP_LD;
    else if (opc == OPC_STORE && f3 == F3_D)
      op = OP_SD;
    else if (opc == OPC_OPIMM && f3 == F3_ADD)
      op = OP_ADDI;
    else if (opc == OPC_OP && f3 == F3_ADD) begin
      if (f7 == F7_ADD)
        op = OP_ADD;
      else if (f7 == F7_SUB)
        op = OP_SUB;
    end
    return op;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate extraction: sign-extended I/S-type immediates,
// zero for any other format.
module imm_gen
  import datapath_seq_pkg::*;
(
  input  logic [31:0] instr,
  output logic [63:0] immediate
);

  logic [6:0] opc;
  logic       unused;

  assign opc    = instr[6:0];
  assign unused = ^instr[19:12];

  always_comb begin
    immediate = '0;
    unique case (1'b1)
      (opc == OPC_LOAD) || (opc == OPC_OPIMM):
        immediate = {{52{instr[31]}}, instr[31:20]};
      (opc == OPC_STORE):
        immediate = {{52{instr[31]}}, instr[31:25],
                     instr[11:7]};
      default: immediate = '0;
    endcase
  end

endmodule

// File: rtl/datapath_sequencer.sv
// Multi-cycle sequencer: captures one RV64 instruction and steps
// EXEC/MEM/WB, producing datapath controls and retire pulses.
module datapath_sequencer
  import datapath_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic        done,
  output logic        illegal_instr,
  output logic [63:0] immediate,
  output logic [4:0]  readRegister1,
  output logic [4:0]  readRegister2,
  output logic [4:0]  writeRegister,
  output logic        writeEnable_DataMemory,
  output logic        writeEnable_Registers,
  output logic        muxSelect_SumVsReadData,
  output logic        muxSelect_ImmVsDataout2,
  output logic        SumOrSub,
  output logic [31:0] retired_count
);

  state_t      state;
  logic [31:0] instr_q;
  op_t         op;
  op_t         op_in;
  logic        rd_nz;

  assign op    = decode(instr_q[6:0], instr_q[14:12],
                        instr_q[31:25]);
  assign op_in = decode(instr[6:0], instr[14:12],
                        instr[31:25]);
  assign rd_nz = (instr_q[11:7] != 5'd0);

  assign readRegister1 = instr_q[19:15];
  assign readRegister2 = instr_q[24:20];
  assign writeRegister = instr_q[11:7];

  imm_gen u_imm_gen (
    .instr     (instr_q),
    .immediate (immediate)
  );

  always_comb begin
    muxSelect_SumVsReadData = 1'b0;
    muxSelect_ImmVsDataout2 = 1'b0;
    SumOrSub                = 1'b0;
    unique case (op)
      OP_LD: muxSelect_ImmVsDataout2 = 1'b1;
      OP_SD, OP_ADDI: begin
        muxSelect_SumVsReadData = 1'b1;
        muxSelect_ImmVsDataout2 = 1'b1;
      end
      OP_ADD: muxSelect_SumVsReadData = 1'b1;
      OP_SUB: begin
        muxSelect_SumVsReadData = 1'b1;
        SumOrSub                = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                  <= IDLE;
      instr_q                <= '0;
      instr_ready            <= 1'b1;
      done                   <= 1'b0;
      illegal_instr          <= 1'b0;
      writeEnable_DataMemory <= 1'b0;
      writeEnable_Registers  <= 1'b0;
      retired_count          <= '0;
    end else begin
      done                   <= 1'b0;
      illegal_instr          <= 1'b0;
      writeEnable_DataMemory <= 1'b0;
      writeEnable_Registers  <= 1'b0;
      if (done)
        retired_count <= retired_count + 32'd1;
      unique case (state)
        IDLE: begin
          if (instr_valid && instr_ready) begin
            instr_q       <= instr;
            state         <= EXEC;
            instr_ready   <= 1'b0;
            illegal_instr <= (op_in == OP_NONE);
          end
        end
        EXEC: begin
          unique case (1'b1)
            (op == OP_NONE): begin
              state       <= IDLE;
              instr_ready <= 1'b1;
            end
            (op == OP_LD) || (op == OP_SD): begin
              state                  <= MEM;
              writeEnable_DataMemory <= (op == OP_SD);
              done                   <= (op == OP_SD);
            end
            default: begin
              state                 <= WB;
              writeEnable_Registers <= rd_nz;
              done                  <= 1'b1;
            end
          endcase
        end
        MEM: begin
          if (op == OP_SD) begin
            state       <= IDLE;
            instr_ready <= 1'b1;
          end else begin
            state                 <= WB;
            writeEnable_Registers <= rd_nz;
            done                  <= 1'b1;
          end
        end
        WB: begin
          state       <= IDLE;
          instr_ready <= 1'b1;
        end
        default: begin
          state       <= IDLE;
          instr_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
